// File: rtl/au_sum_reduce_if.sv
// Bus bundle for au_sum_reduce: per-AU partial-sum inputs, reduction result and status.
// The master side drives start/mask/partial sums and the slave side is the reducer.
interface au_sum_reduce_if #(
    parameter int NUM_AU = 16,
    parameter int DW     = 64
);
    logic                 start;
    logic [NUM_AU-1:0]    au_mask;
    logic [NUM_AU-1:0]    au_sum_vld;
    logic [NUM_AU*DW-1:0] au_sum;
    logic [DW-1:0]        sum;
    logic                 sum_vld;
    logic                 sum_ovrflw;
    logic                 err_timeout;
    logic                 idle;
    logic [2:0]           state;

    modport master (
        output start, au_mask, au_sum_vld, au_sum,
        input  sum, sum_vld, sum_ovrflw, err_timeout, idle, state
    );

    modport slave (
        input  start, au_mask, au_sum_vld, au_sum,
        output sum, sum_vld, sum_ovrflw, err_timeout, idle, state
    );
endinterface

// File: rtl/au_sum_reduce.sv
// Sequentially reduces NUM_AU partial sums into one DW-bit result, one AU per cycle.
// Optional WAIT_VLD watchdog is enabled by defining AU_SUM_REDUCE_TIMEOUT_EN.
module au_sum_reduce #(
    parameter int NUM_AU  = 16,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk_per,
    input  logic            reset_per_n,
    au_sum_reduce_if.slave  bus
);

    localparam int IW = (NUM_AU > 1) ? $clog2(NUM_AU) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_AU - 1);

    if (NUM_AU < 1 || NUM_AU > 64 || DW < 1 || TIMEOUT < 1) begin : g_param_check
        $error("au_sum_reduce: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VLD = 3'd1,
        SUM      = 3'd2,
        FLUSH    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            all_vld;
    logic            last_idx;
    logic            tmo_hit;

    logic [NUM_AU-1:0] r_mask;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     acc;
    logic [DW-1:0]     operand;
    logic [DW:0]       acc_sum;
    logic [DW-1:0]     sum_q;
    logic              sum_vld_q;
    logic              ovrflw_q;
    logic [DW-1:0]     au_word [NUM_AU];

    for (genvar i = 0; i < NUM_AU; i++) begin : g_unpack
        assign au_word[i] = bus.au_sum[i*DW +: DW];
    end

    // Masked-off AUs count as ready so an all-zero mask leaves WAIT_VLD at once.
    assign all_vld  = &(bus.au_sum_vld | ~r_mask);
    assign last_idx = (idx == LAST_IDX);
    assign acc_sum  = {1'b0, acc} + {1'b0, operand};

    always_ff @(posedge clk_per or negedge reset_per_n) begin
        if (!reset_per_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = WAIT_VLD;
                end
            end
            WAIT_VLD: begin
                if (all_vld) begin
                    state_d = SUM;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            SUM: begin
                if (last_idx) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand is registered one cycle ahead of the add, so FLUSH drains the last one.
    always_ff @(posedge clk_per or negedge reset_per_n) begin
        if (!reset_per_n) begin
            r_mask    <= '0;
            idx       <= '0;
            acc       <= '0;
            operand   <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            ovrflw_q  <= 1'b0;
        end else begin
            sum_vld_q <= 1'b0;
            if (accept) begin
                r_mask   <= bus.au_mask;
                idx      <= '0;
                acc      <= '0;
                operand  <= '0;
                ovrflw_q <= 1'b0;
            end
            if (state_q == SUM) begin
                operand <= r_mask[idx] ? au_word[idx] : '0;
                idx     <= last_idx ? '0 : idx + IW'(1);
            end
            if (state_q == SUM || state_q == FLUSH) begin
                acc <= acc_sum[DW-1:0];
                if (acc_sum[DW]) begin
                    ovrflw_q <= 1'b1;
                end
            end
            if (state_q == DONE) begin
                sum_q     <= acc;
                sum_vld_q <= 1'b1;
            end
        end
    end

`ifdef AU_SUM_REDUCE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Accumulator is still zero on a timeout, so DONE publishes sum=0.
    always_ff @(posedge clk_per or negedge reset_per_n) begin
        if (!reset_per_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (state_q == WAIT_VLD) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit && !all_vld) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit         = (tmo_cnt == TW'(TIMEOUT - 1));
    assign bus.err_timeout = err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.sum        = sum_q;
    assign bus.sum_vld    = sum_vld_q;
    assign bus.sum_ovrflw = ovrflw_q;
    assign bus.state      = state_q;
    assign bus.idle       = (state_q == IDLE) && !bus.start;

endmodule

// File: tb/tb_au_sum_reduce.sv
// Directed self-checking bench for au_sum_reduce with NUM_AU=4, DW=8.
// Covers latency, masking, overflow, reset abort, ignored start and the WAIT_VLD watchdog.
module tb_au_sum_reduce;

    logic clk_per;
    logic reset_per_n;
    int   errors;
    int   checks;

    au_sum_reduce_if #(.NUM_AU(4), .DW(8)) bus ();

    au_sum_reduce #(.NUM_AU(4), .DW(8), .TIMEOUT(8)) dut (
        .clk_per     (clk_per),
        .reset_per_n (reset_per_n),
        .bus         (bus)
    );

    initial clk_per = 1'b0;
    always #5 clk_per = ~clk_per;

    task automatic tick();
        @(posedge clk_per);
        #1;
    endtask

    // Starts a reduction, presents sums/valids, returns WAIT_VLD cycles and exit-to-sum_vld edges.
    task automatic run_sum(input logic [3:0] mask, input logic [31:0] sums,
                           input logic [3:0] vld, output int wait_n, output int lat);
        bus.start   = 1'b1;
        bus.au_mask = mask;
        tick();
        bus.start      = 1'b0;
        bus.au_sum     = sums;
        bus.au_sum_vld = vld;
        wait_n = 0;
        while (bus.state != 3'd2 && wait_n < 40) begin
            tick();
            wait_n++;
        end
        lat = 0;
        while (!bus.sum_vld && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.sum !== 8'd0) begin errors++; $display("[TB] FAIL reset_sum: got %0h want 0", bus.sum); end
        checks++; if (bus.sum_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_sum_vld: got %b want 0", bus.sum_vld); end
        checks++; if (bus.sum_ovrflw !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovrflw: got %b want 0", bus.sum_ovrflw); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_timeout); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b want 1", bus.idle); end
        reset_per_n = 1'b1;
        tick();
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle: got %b want 1", bus.idle); end
    endtask

    task automatic test_full_mask();
        int lat;
        bus.start   = 1'b1;
        bus.au_mask = 4'hF;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd1) begin errors++; $display("[TB] FAIL full_wait_state: got %0d want 1", bus.state); end
        bus.au_sum     = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.au_sum_vld = 4'hF;
        tick();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("[TB] FAIL full_sum_state: got %0d want 2", bus.state); end
        lat = 0;
        while (!bus.sum_vld && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL full_latency: got %0d want 6", lat); end
        checks++; if (bus.sum !== 8'd10) begin errors++; $display("[TB] FAIL full_sum: got %0d want 10", bus.sum); end
        checks++; if (bus.sum_ovrflw !== 1'b0) begin errors++; $display("[TB] FAIL full_ovrflw: got %b want 0", bus.sum_ovrflw); end
        tick();
        checks++; if (bus.sum_vld !== 1'b0) begin errors++; $display("[TB] FAIL full_vld_pulse: got %b want 0", bus.sum_vld); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL full_back_idle: got %0d want 0", bus.state); end
        checks++; if (bus.sum !== 8'd10) begin errors++; $display("[TB] FAIL full_sum_hold: got %0d want 10", bus.sum); end
    endtask

    task automatic test_partial_mask();
        int wait_n;
        int lat;
        run_sum(4'b0101, {8'd99, 8'd20, 8'd99, 8'd10}, 4'b0101, wait_n, lat);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL partial_latency: got %0d want 6", lat); end
        checks++; if (bus.sum !== 8'd30) begin errors++; $display("[TB] FAIL partial_sum: got %0d want 30", bus.sum); end
        tick();
    endtask

    task automatic test_zero_mask();
        int wait_n;
        int lat;
        run_sum(4'b0000, {8'd7, 8'd7, 8'd7, 8'd7}, 4'b0000, wait_n, lat);
        checks++; if (wait_n !== 1) begin errors++; $display("[TB] FAIL zero_wait_cycles: got %0d want 1", wait_n); end
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL zero_latency: got %0d want 6", lat); end
        checks++; if (bus.sum !== 8'd0) begin errors++; $display("[TB] FAIL zero_sum: got %0d want 0", bus.sum); end
        tick();
    endtask

    task automatic test_overflow();
        int wait_n;
        int lat;
        run_sum(4'hF, {8'h00, 8'h00, 8'h02, 8'hFF}, 4'hF, wait_n, lat);
        checks++; if (bus.sum !== 8'h01) begin errors++; $display("[TB] FAIL ovf_sum: got %0h want 01", bus.sum); end
        checks++; if (bus.sum_ovrflw !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b want 1", bus.sum_ovrflw); end
        tick();
        checks++; if (bus.sum_ovrflw !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", bus.sum_ovrflw); end
        bus.au_sum_vld = 4'h0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.sum_ovrflw !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_on_start: got %b want 0", bus.sum_ovrflw); end
        checks++; if (bus.sum !== 8'h01) begin errors++; $display("[TB] FAIL ovf_sum_hold: got %0h want 01", bus.sum); end
        bus.au_sum     = {8'd8, 8'd7, 8'd6, 8'd5};
        bus.au_sum_vld = 4'hF;
        lat = 0;
        while (!bus.sum_vld && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (bus.sum !== 8'd26) begin errors++; $display("[TB] FAIL ovf_next_sum: got %0d want 26", bus.sum); end
        tick();
    endtask

    task automatic test_mid_reset();
        int seen;
        int lat;
        bus.start   = 1'b1;
        bus.au_mask = 4'hF;
        tick();
        bus.start      = 1'b0;
        bus.au_sum     = {8'd1, 8'd2, 8'd3, 8'd4};
        bus.au_sum_vld = 4'hF;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd2) begin errors++; $display("[TB] FAIL ignored_start_state: got %0d want 2", bus.state); end
        checks++; if (bus.idle !== 1'b0) begin errors++; $display("[TB] FAIL busy_idle: got %b want 0", bus.idle); end
        reset_per_n = 1'b0;
        #1;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL midrst_state: got %0d want 0", bus.state); end
        checks++; if (bus.sum !== 8'd0) begin errors++; $display("[TB] FAIL midrst_sum: got %0d want 0", bus.sum); end
        checks++; if (bus.sum_vld !== 1'b0) begin errors++; $display("[TB] FAIL midrst_vld: got %b want 0", bus.sum_vld); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle: got %b want 1", bus.idle); end
        tick();
        reset_per_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sum_vld) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midrst_no_vld: got %0d pulses want 0", seen); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.state !== 3'd1) begin errors++; $display("[TB] FAIL post_rst_accept: got %0d want 1", bus.state); end
        lat = 0;
        while (!bus.sum_vld && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (bus.sum !== 8'd10) begin errors++; $display("[TB] FAIL post_rst_sum: got %0d want 10", bus.sum); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int seen;
        bus.start      = 1'b1;
        bus.au_mask    = 4'hF;
        bus.au_sum     = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.au_sum_vld = 4'h7;
        tick();
        bus.start = 1'b0;
`ifdef AU_SUM_REDUCE_TIMEOUT_EN
        n = 0;
        while (!bus.sum_vld && n < 40) begin
            tick();
            n++;
        end
        checks++; if (bus.sum_vld !== 1'b1) begin errors++; $display("[TB] FAIL tmo_vld: got %b want 1", bus.sum_vld); end
        checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err: got %b want 1", bus.err_timeout); end
        checks++; if (bus.sum !== 8'd0) begin errors++; $display("[TB] FAIL tmo_sum: got %0d want 0", bus.sum); end
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL tmo_idle_state: got %0d want 0", bus.state); end
        seen = n;
`else
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.sum_vld) seen++;
        end
        checks++; if (bus.state !== 3'd1) begin errors++; $display("[TB] FAIL wait_forever_state: got %0d want 1", bus.state); end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL wait_forever_vld: got %0d pulses want 0", seen); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wait_forever_err: got %b want 0", bus.err_timeout); end
        bus.au_sum_vld = 4'hF;
        n = 0;
        while (!bus.sum_vld && n < 40) begin
            tick();
            n++;
        end
        checks++; if (bus.sum !== 8'd4) begin errors++; $display("[TB] FAIL wait_release_sum: got %0d want 4", bus.sum); end
`endif
        tick();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset_per_n    = 1'b0;
        bus.start      = 1'b0;
        bus.au_mask    = '0;
        bus.au_sum_vld = '0;
        bus.au_sum     = '0;
        #12;
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_zero_mask();
        test_overflow();
        test_mid_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/au_sum_reduce.md
AU_SUM_REDUCE -- requirements
Module: au_sum_reduce

Interface
REQ-001 Parameter NUM_AU, default 16: number of arithmetic units (AUs) whose partial sums are reduced; legal range 1..64.
REQ-002 Parameter DW, default 64: width of each partial sum and of the result.
REQ-003 Parameter TIMEOUT, default 1024: WAIT_VLD watchdog limit in cycles; used only when the configuration macro is defined (REQ-026).
REQ-004 clk_per  in  1  personality clock; the block's only clock.
REQ-005 reset_per_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a reduction.
REQ-007 au_mask  in  NUM_AU  per-AU enable; sampled when start is accepted.
REQ-008 au_sum_vld  in  NUM_AU  per-AU level "partial sum ready".
REQ-009 au_sum  in  NUM_AU*DW  packed partial sums; AU i occupies bits [i*DW +: DW].
REQ-010 sum  out  DW  reduction result.
REQ-011 sum_vld  out  1  one-cycle pulse; sum is valid in that cycle and afterwards.
REQ-012 sum_ovrflw  out  1  sticky carry-out flag for the current/last reduction.
REQ-013 err_timeout  out  1  sticky watchdog error flag.
REQ-014 idle  out  1  high when state is IDLE and no start is pending.
REQ-015 state  out  3  current state encoding, exported for CSR status.

Function
REQ-016 State encoding: IDLE=0, WAIT_VLD=1, SUM=2, FLUSH=3, DONE=4; any other encoding goes to IDLE on the next cycle.
REQ-017 In IDLE, start=1 is accepted:
- au_mask is captured into r_mask.
- Accumulator, index counter, sum_ovrflw and err_timeout are cleared.
- Next state is WAIT_VLD.
REQ-018 start is ignored in every state other than IDLE; no queuing.
REQ-019 WAIT_VLD goes to SUM on the first cycle in which (au_sum_vld | ~r_mask) is all ones. An all-zero mask passes through WAIT_VLD in exactly one cycle.
REQ-020 SUM lasts exactly NUM_AU cycles; index k = 0..NUM_AU-1 advances by one per cycle.
- In cycle k the operand register loads au_sum[k], or zero if r_mask[k]=0.
- The accumulator adds the operand registered in the previous cycle.
REQ-021 After index NUM_AU-1, the block goes to FLUSH for one cycle to add the final operand, then to DONE.
REQ-022 DONE lasts one cycle:
- sum_vld=1.
- sum is loaded from the accumulator.
- Next state is IDLE.
- sum holds its value until the next DONE.
REQ-023 Latency from the WAIT_VLD exit edge to sum_vld is NUM_AU+2 cycles, independent of the mask.
REQ-024 Arithmetic is unsigned, DW+1 bits wide. Any carry out of bit DW-1 sets sum_ovrflw, which stays set until the next accepted start. The accumulator wraps modulo 2^DW.
REQ-025 idle = (state==IDLE) && !start. state reflects the registered state.

Configuration
REQ-026 Macro AU_SUM_REDUCE_TIMEOUT_EN.
- When defined, a counter runs in WAIT_VLD. If the condition in REQ-019 is not met within TIMEOUT cycles, the block sets err_timeout and goes to DONE. sum_vld still pulses, with sum=0.
- When undefined, there is no counter, err_timeout is tied to 0, and WAIT_VLD waits indefinitely.

Reset
REQ-027 While reset_per_n=0, asynchronously: state=IDLE, accumulator=0, operand=0, index=0, r_mask=0, sum=0, sum_vld=0, sum_ovrflw=0, err_timeout=0.
REQ-028 Asserting reset in any state, including mid-SUM, aborts the reduction with no sum_vld pulse. After deassertion the block is idle=1 and ready to accept start on the first clock edge.

Verification
REQ-029 The bench shall use NUM_AU=4 and DW=8 unless a scenario states otherwise.
REQ-030 Full mask: start, mask=4'hF, sums {1,2,3,4}, vld=4'hF one cycle after start -> sum_vld pulses exactly 6 cycles after WAIT_VLD exit, sum=8'd10, sum_ovrflw=0.
REQ-031 Partial mask: mask=4'b0101, sums {10,99,20,99}, vld=4'b0101 -> sum=8'd30; masked AUs 1 and 3 need not be valid.
REQ-032 Overflow: mask=4'hF, sums {8'hFF,8'h02,0,0} -> sum=8'h01, sum_ovrflw=1. A following start clears sum_ovrflw in the cycle after acceptance.
REQ-033 Mid-operation reset and ignored start: reset_per_n pulsed low during SUM index 2 -> no sum_vld, all outputs 0, idle=1. A start pulse applied during SUM is ignored, with state unchanged.
REQ-034 Timeout: macro defined, TIMEOUT=8, mask=4'hF, vld=4'h7 held -> err_timeout=1, sum_vld pulses with sum=0, and the block returns to IDLE. With the macro undefined the block stays in WAIT_VLD (state=1) indefinitely.
